// File: rtl/image_gray2pseudo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : image_gray2pseudo_pkg
// Purpose : Shared widths, LUT geometry, FSM state type and the default
//           rainbow-ramp generator for the gray-to-pseudo-colour block.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package image_gray2pseudo_pkg;

   localparam int GRAY_W    = 8;
   localparam int RGB_W     = 24;
   localparam int LUT_DEPTH = 256;
   localparam int LUT_AW    = $clog2(LUT_DEPTH);
   localparam int PIPE_LAT  = 3;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } lut_state_t;

   // Four 64-level segments: blue->cyan, cyan->green, green->yellow,
   // yellow->red. q is the position inside the segment scaled to 0..252.
   function automatic logic [RGB_W-1:0] ramp(input logic [GRAY_W-1:0] g);
      logic [7:0] q;
      q    = {g[5:0], 2'b00};
      ramp = '0;
      case (g[7:6])
         2'd0:    ramp = {8'h00, q, 8'hFF};
         2'd1:    ramp = {8'h00, 8'hFF, 8'hFF - q};
         2'd2:    ramp = {q, 8'hFF, 8'h00};
         default: ramp = {8'hFF, 8'hFF - q, 8'h00};
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/image_gray2pseudo_lut_ram.sv
`default_nettype none
// ============================================================================
// Module  : pseudo_lut_ram
// Purpose : Simple dual-port RAM holding the pseudo-colour palette. One write
//           port, one synchronous read-first read port, no reset on storage
//           or read data so it maps onto block RAM.
// Ports   : clk           pixel clock
//           we/waddr/wdata write port
//           raddr/rdata    read port, rdata valid one clock after raddr
// Rev     : 1.0  initial release
// ============================================================================
module pseudo_lut_ram
   import image_gray2pseudo_pkg::*;
#(
   parameter int DEPTH = LUT_DEPTH,
   parameter int AW    = LUT_AW,
   parameter int DW    = RGB_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Read and write share one edge; the read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/image_gray2pseudo.sv
`default_nettype none
// ============================================================================
// Module  : image_gray2pseudo
// Purpose : Maps a replicated gray pixel stream to 24-bit pseudo-colour via a
//           256-entry palette LUT. The LUT self-loads a rainbow ramp after
//           reset; software may overwrite entries once loading is finished.
//           Data/valid/vs/hs all see a fixed 3-cycle delay.
// Ports   : clk, reset                 clock, synchronous active-high reset
//           vs_in, hs_in               syncs, delayed 3 cycles to vs_out/hs_out
//           valid_i, img_data_i        pixel qualifier and {G,G,G} pixel
//           bypass                     1: output gray, 0: output LUT colour
//           lut_we, lut_addr, lut_wdata software LUT write port
//           init_done                  high once the ramp is loaded
//           valid_o, img_data_o        delayed qualifier and {R,G,B} pixel
// Rev     : 1.0  initial release
// ============================================================================
module image_gray2pseudo
   import image_gray2pseudo_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              vs_in,
   input  logic              hs_in,
   input  logic              valid_i,
   input  logic [RGB_W-1:0]  img_data_i,
   input  logic              bypass,
   input  logic              lut_we,
   input  logic [LUT_AW-1:0] lut_addr,
   input  logic [RGB_W-1:0]  lut_wdata,
   output logic              init_done,
   output logic              vs_out,
   output logic              hs_out,
   output logic              valid_o,
   output logic [RGB_W-1:0]  img_data_o
);

   lut_state_t        state;
   lut_state_t        state_nxt;
   logic [LUT_AW-1:0] init_cnt;

   logic              ram_we;
   logic [LUT_AW-1:0] ram_waddr;
   logic [RGB_W-1:0]  ram_wdata;
   logic [RGB_W-1:0]  lut_rdata;

   logic [PIPE_LAT-1:0] vs_dly;
   logic [PIPE_LAT-1:0] hs_dly;

   logic              s1_valid;
   logic              s1_bypass;
   logic [GRAY_W-1:0] s1_gray;
   logic              s2_valid;
   logic [RGB_W-1:0]  s2_data;

   // Only the low gray byte indexes the LUT; the replicated copies are unused.
   logic unused_gray_copies;
   assign unused_gray_copies = &{1'b0, img_data_i[RGB_W-1:GRAY_W]};

   // ------------------------------------------------------------------------
   // Loader FSM: INIT walks every address once, then RUN hands the write
   // port to software for good.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= INIT;
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         init_done <= (state_nxt == RUN);
         if (state == INIT) begin
            init_cnt <= init_cnt + LUT_AW'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ram_we    = 1'b0;
      ram_waddr = lut_addr;
      ram_wdata = lut_wdata;
      case (state)
         INIT: begin
            ram_we    = 1'b1;
            ram_waddr = init_cnt;
            ram_wdata = ramp(init_cnt);
            if (init_cnt == LUT_AW'(LUT_DEPTH - 1)) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            ram_we = lut_we;
         end
         default: begin
            state_nxt = INIT;
         end
      endcase
   end

   // The RAM is addressed straight from the input pixel so its read edge is
   // the S1 edge: a software write presented alongside a pixel of the same
   // level is not visible to that pixel, only to later ones.
   pseudo_lut_ram #(
      .DEPTH (LUT_DEPTH),
      .AW    (LUT_AW),
      .DW    (RGB_W)
   ) u_lut (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (img_data_i[GRAY_W-1:0]),
      .rdata (lut_rdata)
   );

   // ------------------------------------------------------------------------
   // Pixel pipeline and sync delay lines.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         vs_dly     <= '0;
         hs_dly     <= '0;
         s1_valid   <= 1'b0;
         s1_bypass  <= 1'b0;
         s1_gray    <= '0;
         s2_valid   <= 1'b0;
         s2_data    <= '0;
         valid_o    <= 1'b0;
         img_data_o <= '0;
      end else begin
         vs_dly <= {vs_dly[PIPE_LAT-2:0], vs_in};
         hs_dly <= {hs_dly[PIPE_LAT-2:0], hs_in};

         // S1: pixels arriving while the ramp is still loading are dropped.
         s1_valid  <= valid_i & (state == RUN);
         s1_bypass <= bypass;
         s1_gray   <= img_data_i[GRAY_W-1:0];

         // S2: RAM data is now aligned with the S1 pixel.
         s2_valid <= s1_valid;
         s2_data  <= s1_bypass ? {3{s1_gray}} : lut_rdata;

         // S3: colour output holds through invalid cycles.
         valid_o <= s2_valid;
         if (s2_valid) begin
            img_data_o <= s2_data;
         end
      end
   end

   assign vs_out = vs_dly[PIPE_LAT-1];
   assign hs_out = hs_dly[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_image_gray2pseudo.sv
`default_nettype none
// ============================================================================
// Module  : tb_image_gray2pseudo
// Purpose : Self-checking bench for image_gray2pseudo. A cycle-level
//           behavioural model (palette array + 3-deep delay queue) is checked
//           every cycle, and directed pixels are checked against
//           hand-computed colours.
// Rev     : 1.0  initial release
// ============================================================================
module tb_image_gray2pseudo;

   logic        clk = 1'b0;
   logic        reset;
   logic        vs_in, hs_in, valid_i, bypass, lut_we;
   logic [23:0] img_data_i, lut_wdata;
   logic [7:0]  lut_addr;
   logic        init_done, vs_out, hs_out, valid_o;
   logic [23:0] img_data_o;

   int vectors     = 0;
   int miscompares = 0;

   image_gray2pseudo dut (
      .clk        (clk),
      .reset      (reset),
      .vs_in      (vs_in),
      .hs_in      (hs_in),
      .valid_i    (valid_i),
      .img_data_i (img_data_i),
      .bypass     (bypass),
      .lut_we     (lut_we),
      .lut_addr   (lut_addr),
      .lut_wdata  (lut_wdata),
      .init_done  (init_done),
      .vs_out     (vs_out),
      .hs_out     (hs_out),
      .valid_o    (valid_o),
      .img_data_o (img_data_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Default palette from the segment rules, in plain arithmetic.
   function automatic logic [23:0] spec_ramp(input int g);
      int q;
      int r, gr, b;
      q = (g % 64) * 4;
      case (g / 64)
         0:       begin r = 0;   gr = q;       b = 255;     end
         1:       begin r = 0;   gr = 255;     b = 255 - q; end
         2:       begin r = q;   gr = 255;     b = 0;       end
         default: begin r = 255; gr = 255 - q; b = 0;       end
      endcase
      return {8'(r), 8'(gr), 8'(b)};
   endfunction

   // ------------------------------------------------------------------------
   // Behavioural model + per-cycle compare.
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic        v;
      logic [23:0] d;
      logic        vs;
      logic        hs;
   } slot_t;

   slot_t       pipe [3];
   logic [23:0] m_lut [256];
   int          m_cyc  = 0;
   bit          m_done = 1'b0;
   logic [23:0] m_data = '0;

   always begin : model_proc
      slot_t nw;
      @(posedge clk);
      #1;
      if (reset) begin
         for (int i = 0; i < 3; i++) pipe[i] = '0;
         for (int g = 0; g < 256; g++) m_lut[g] = spec_ramp(g);
         m_cyc  = 0;
         m_done = 1'b0;
         m_data = '0;
      end else begin
         nw.v  = m_done && valid_i;
         nw.d  = bypass ? {3{img_data_i[7:0]}} : m_lut[img_data_i[7:0]];
         nw.vs = vs_in;
         nw.hs = hs_in;
         if (m_done && lut_we) m_lut[lut_addr] = lut_wdata;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = nw;
         if (pipe[2].v) m_data = pipe[2].d;
         m_cyc++;
         m_done = (m_cyc >= 256);
      end
      chk("model_init_done", init_done,  m_done);
      chk("model_valid_o",   valid_o,    pipe[2].v);
      chk("model_vs_out",    vs_out,     pipe[2].vs);
      chk("model_hs_out",    hs_out,     pipe[2].hs);
      chk("model_img_data",  img_data_o, m_data);
   end

   // ------------------------------------------------------------------------
   // Directed stimulus (inputs change on the falling edge).
   // ------------------------------------------------------------------------
   task automatic idle();
      vs_in = 0; hs_in = 0; valid_i = 0; bypass = 0;
      lut_we = 0; lut_addr = '0; lut_wdata = '0; img_data_i = '0;
   endtask

   // Called on the falling edge right after reset is released.
   task automatic wait_init(input string nm);
      int n;
      n = 0;
      while (n < 300) begin
         vs_in      = (n % 7) < 2;
         hs_in      = (n % 3) == 0;
         valid_i    = 1'b1;
         img_data_i = {3{8'(n)}};
         lut_we     = 1'b1;
         lut_addr   = 8'd50;
         lut_wdata  = 24'hDEAD00;
         @(posedge clk);
         #1;
         n++;
         if (init_done) break;
         @(negedge clk);
      end
      @(negedge clk);
      idle();
      chk(nm, n, 256);
   endtask

   // Single pixel, checked 3 cycles later. Starts and ends on a falling edge.
   task automatic pix(input string nm, input logic [7:0] g, input logic b, input logic [23:0] exp);
      valid_i = 1'b1; img_data_i = {3{g}}; bypass = b;
      @(negedge clk);
      valid_i = 1'b0; bypass = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk(nm, img_data_o, exp);
      chk({nm, "_valid"}, valid_o, 1'b1);
      @(negedge clk);
   endtask

   logic [7:0] gtab [8] = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};

   initial begin
      reset = 1'b1;
      idle();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wait_init("init_latency");

      // Writes attempted during INIT must not have landed.
      pix("g50_after_init", 8'd50, 1'b0, 24'h00C8FF);
      pix("g0",   8'd0,   1'b0, 24'h0000FF);
      pix("g63",  8'd63,  1'b0, 24'h00FCFF);
      pix("g100", 8'd100, 1'b0, 24'h00FF6F);
      pix("g200", 8'd200, 1'b0, 24'hFFDF00);
      pix("g255", 8'd255, 1'b0, 24'hFF0300);
      pix("byp5a", 8'h5A, 1'b1, 24'h5A5A5A);

      // Bypass toggled between adjacent pixels.
      valid_i = 1'b1; img_data_i = '0; bypass = 1'b1;
      @(negedge clk);
      bypass = 1'b0;
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      chk("toggle_first_bypass", img_data_o, 24'h000000);
      @(posedge clk); #1;
      chk("toggle_second_lut", img_data_o, 24'h0000FF);
      @(negedge clk);

      // Streaming with per-pixel bypass, gaps and sync patterns.
      for (int i = 0; i < 24; i++) begin
         valid_i    = (i % 5) != 3;
         img_data_i = {3{gtab[i % 8]}};
         bypass     = i[0];
         vs_in      = (i % 11) < 2;
         hs_in      = (i % 4) == 1;
         @(negedge clk);
      end
      idle();
      repeat (4) @(negedge clk);

      // Single vs pulse in RUN.
      vs_in = 1'b1;
      @(negedge clk);
      vs_in = 1'b0;
      @(posedge clk); #1;
      chk("vs_pulse_early", vs_out, 1'b0);
      @(posedge clk); #1;
      chk("vs_pulse_hit", vs_out, 1'b1);
      @(posedge clk); #1;
      chk("vs_pulse_after", vs_out, 1'b0);
      @(negedge clk);

      // Software write, then read.
      lut_we = 1'b1; lut_addr = 8'd50; lut_wdata = 24'h123456;
      @(negedge clk);
      lut_we = 1'b0;
      pix("wr50_read", 8'd50, 1'b0, 24'h123456);

      // Write and read of the same entry in one cycle, then a later read.
      lut_we = 1'b1; lut_addr = 8'd50; lut_wdata = 24'hABCDEF;
      valid_i = 1'b1; img_data_i = {3{8'd50}}; bypass = 1'b0;
      @(negedge clk);
      lut_we = 1'b0;
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      chk("same_cycle_old", img_data_o, 24'h123456);
      @(posedge clk); #1;
      chk("next_read_new", img_data_o, 24'hABCDEF);
      @(negedge clk);

      // Reset in the middle of a busy line.
      for (int i = 0; i < 4; i++) begin
         valid_i = 1'b1; img_data_i = {3{8'(200 + i)}}; vs_in = 1'b1; hs_in = 1'b1;
         @(negedge clk);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_img_data", img_data_o, 24'h0);
      chk("rst_valid_o",  valid_o,    1'b0);
      chk("rst_vs_out",   vs_out,     1'b0);
      chk("rst_hs_out",   hs_out,     1'b0);
      chk("rst_init_done", init_done, 1'b0);
      @(negedge clk);
      idle();
      reset = 1'b0;
      wait_init("reinit_latency");
      pix("g50_restored", 8'd50, 1'b0, 24'h00C8FF);

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
